// File: rtl/mbst_pkg.sv
// Shared types and helpers for the serial sum-threshold unit and its compare cell.
package mbst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int unsigned CMP_MODE_GT = 0;
  localparam int unsigned CMP_MODE_GE = 1;

  // Accumulator width that holds n_ops * (2^w - 1) without overflow.
  function automatic int unsigned acc_w(input int unsigned w, input int unsigned n_ops);
    return w + $clog2(n_ops);
  endfunction

endpackage

// File: rtl/mbst_serial_threshold_if.sv
// Operand stream in, decision stream out, bundled for the threshold unit.
interface mbst_serial_threshold_if #(
  parameter int unsigned W     = 3,
  parameter int unsigned THR_W = W,
  parameter int unsigned ACC_W = W + 1
) ();
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [THR_W-1:0] in_thr;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [ACC_W-1:0] out_sum;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_thr, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_sum, out_err
  );

  modport master (
    output in_valid, in_data, in_thr, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_sum, out_err
  );
endinterface

// File: rtl/mbst_cmp.sv
// Magnitude compare of a sum against a threshold, GT or GE selected at elaboration.
module mbst_cmp
  import mbst_pkg::*;
#(
  parameter int unsigned ACC_W  = 4,
  parameter int unsigned CMP_GE = CMP_MODE_GT
) (
  input  logic [ACC_W-1:0] sum,
  input  logic [ACC_W-1:0] thr,
  output logic             hit
);

  // Decision bit for the selected compare mode.
  always_comb begin
    hit = (CMP_GE == CMP_MODE_GE) ? (sum >= thr) : (sum > thr);
  end

endmodule

// File: rtl/mbst_serial_threshold.sv
// Serial multi-operand sum-threshold unit: accumulates up to N_OPS beats per frame,
// compares the exact sum to the threshold captured on the first beat, and holds the
// result in a one-entry output buffer that can drain and refill in the same cycle.
module mbst_serial_threshold
  import mbst_pkg::*;
#(
  parameter int unsigned W      = 3,
  parameter int unsigned N_OPS  = 2,
  parameter int unsigned THR_W  = W,
  parameter int unsigned CMP_GE = CMP_MODE_GT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mbst_serial_threshold_if.slave bus
);

  localparam int unsigned ACC_W = acc_w(W, N_OPS);
  localparam int unsigned CNT_W = $clog2(N_OPS + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] thr_q, thr_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_bit_q, out_bit_d;
  logic             out_err_q, out_err_d;

  logic             in_ready;
  logic             beat;
  logic             first;
  logic             close;
  logic             drain;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ACC_W-1:0] thr_cur;
  logic             hit;

  assign in_ready      = (state_q != FULL) | bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_err   = out_err_q;

  // Compare against the sum including the current beat so the result is ready on close.
  mbst_cmp #(
    .ACC_W  (ACC_W),
    .CMP_GE (CMP_GE)
  ) u_cmp (
    .sum (acc_nxt),
    .thr (thr_cur),
    .hit (hit)
  );

  // Beat datapath: a frame starts on any beat taken outside ACCUM (IDLE, or FULL while draining).
  always_comb begin
    beat    = bus.in_valid & in_ready;
    first   = (state_q != ACCUM);
    drain   = (state_q == FULL) & bus.out_ready;
    acc_nxt = first ? ACC_W'(bus.in_data) : acc_q + ACC_W'(bus.in_data);
    cnt_nxt = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    thr_cur = first ? ACC_W'(bus.in_thr) : thr_q;
    close   = beat & (bus.in_last | (cnt_nxt == CNT_W'(N_OPS)));
  end

  // Next state and output-buffer load; a closing beat always refills the buffer,
  // so FULL is reached whether or not the previous result drained this cycle.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    out_sum_d = out_sum_q;
    out_bit_d = out_bit_q;
    out_err_d = out_err_q;
    if (beat) begin
      acc_d = acc_nxt;
      cnt_d = cnt_nxt;
      thr_d = thr_cur;
    end
    if (close) begin
      state_d   = FULL;
      cnt_d     = '0;
      out_sum_d = acc_nxt;
      out_bit_d = hit;
      out_err_d = (cnt_nxt != CNT_W'(N_OPS)) | ~bus.in_last;
    end else if (beat) begin
      state_d = ACCUM;
    end else if (drain) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      thr_q     <= '0;
      out_sum_q <= '0;
      out_bit_q <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      thr_q     <= thr_d;
      out_sum_q <= out_sum_d;
      out_bit_q <= out_bit_d;
      out_err_q <= out_err_d;
    end
  end

endmodule

// File: tb/tb_mbst_serial_threshold.sv
// Bench for mbst_serial_threshold: two configurations share one input stream
// (A: W=3,N_OPS=2,GT; B: W=4,N_OPS=8,GE), each tracked by a frame-level model.
module tb_mbst_serial_threshold;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic [3:0] in_thr = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       cmp_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mbst_serial_threshold_if #(.W(3), .THR_W(3), .ACC_W(4)) ia ();
  mbst_serial_threshold_if #(.W(4), .THR_W(4), .ACC_W(7)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.in_data   = in_data[2:0];
  assign ia.in_thr    = in_thr[2:0];
  assign ia.in_last   = in_last;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_data   = in_data;
  assign ib.in_thr    = in_thr;
  assign ib.in_last   = in_last;
  assign ib.out_ready = out_ready;

  mbst_serial_threshold #(.W(3), .N_OPS(2), .THR_W(3), .CMP_GE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  mbst_serial_threshold #(.W(4), .N_OPS(8), .THR_W(4), .CMP_GE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  // Frame-level model: beats seen so far in the open frame, and the buffered result.
  int m_cnt [2];
  int m_sum [2];
  int m_thr [2];
  int m_full[2];
  int m_osum[2];
  int m_obit[2];
  int m_oerr[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_sum[k] = 0; m_thr[k] = 0; m_full[k] = 0;
      m_osum[k] = 0; m_obit[k] = 0; m_oerr[k] = 0;
    end
  end

  task automatic model_step(input int k, input int n, input int ge, input int mask);
    int rdy;
    int d;
    if (!rst_n) begin
      m_cnt[k] = 0; m_sum[k] = 0; m_thr[k] = 0; m_full[k] = 0;
      m_osum[k] = 0; m_obit[k] = 0; m_oerr[k] = 0;
    end else begin
      rdy = (m_full[k] == 0 || out_ready) ? 1 : 0;
      if (m_full[k] != 0 && out_ready) m_full[k] = 0;
      if (in_valid && rdy != 0) begin
        d = int'(in_data) & mask;
        if (m_cnt[k] == 0) begin
          m_sum[k] = d;
          m_thr[k] = int'(in_thr) & mask;
        end else begin
          m_sum[k] = m_sum[k] + d;
        end
        m_cnt[k] = m_cnt[k] + 1;
        if (in_last || m_cnt[k] == n) begin
          m_full[k] = 1;
          m_osum[k] = m_sum[k];
          m_obit[k] = (ge != 0) ? int'(m_sum[k] >= m_thr[k]) : int'(m_sum[k] > m_thr[k]);
          m_oerr[k] = (m_cnt[k] != n || !in_last) ? 1 : 0;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0, 2, 0, 7);
      model_step(1, 8, 1, 15);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("A.in_ready",  32'(ia.in_ready),  32'((m_full[0] == 0 || out_ready) ? 1 : 0));
        chk("A.out_valid", 32'(ia.out_valid), 32'(m_full[0]));
        chk("A.out_sum",   32'(ia.out_sum),   32'(m_osum[0]));
        chk("A.out_bit",   32'(ia.out_bit),   32'(m_obit[0]));
        chk("A.out_err",   32'(ia.out_err),   32'(m_oerr[0]));
        chk("B.in_ready",  32'(ib.in_ready),  32'((m_full[1] == 0 || out_ready) ? 1 : 0));
        chk("B.out_valid", 32'(ib.out_valid), 32'(m_full[1]));
        chk("B.out_sum",   32'(ib.out_sum),   32'(m_osum[1]));
        chk("B.out_bit",   32'(ib.out_bit),   32'(m_obit[1]));
        chk("B.out_err",   32'(ib.out_err),   32'(m_oerr[1]));
      end
    end
  end

  task automatic send(input int d, input int t, input int last);
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_thr   = 4'(t);
    in_last  = last[0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".A.valid"}, 32'(ia.out_valid), 32'd0);
    chk({tag, ".A.sum"},   32'(ia.out_sum),   32'd0);
    chk({tag, ".A.bit"},   32'(ia.out_bit),   32'd0);
    chk({tag, ".A.err"},   32'(ia.out_err),   32'd0);
    chk({tag, ".B.valid"}, 32'(ib.out_valid), 32'd0);
    chk({tag, ".B.sum"},   32'(ib.out_sum),   32'd0);
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk_zero("reset");

    // A: 5+4 > 7, latency one cycle after the last beat.
    send(5, 7, 0);
    chk("t1.A.valid_early", 32'(ia.out_valid), 32'd0);
    send(4, 7, 1);
    chk("t1.A.valid", 32'(ia.out_valid), 32'd1);
    chk("t1.A.sum",   32'(ia.out_sum),   32'd9);
    chk("t1.A.bit",   32'(ia.out_bit),   32'd1);
    chk("t1.A.err",   32'(ia.out_err),   32'd0);

    // 1+2 vs 3: GT gives 0 on A, GE gives 1 on B (short frame on B).
    do_reset();
    send(1, 3, 0);
    send(2, 3, 1);
    chk("t2.A.sum", 32'(ia.out_sum), 32'd3);
    chk("t2.A.bit", 32'(ia.out_bit), 32'd0);
    chk("t2.B.sum", 32'(ib.out_sum), 32'd3);
    chk("t2.B.bit", 32'(ib.out_bit), 32'd1);
    chk("t2.B.err", 32'(ib.out_err), 32'd1);

    // B: eight beats of 15 reach 120 in a 7-bit accumulator.
    do_reset();
    for (int i = 0; i < 8; i++) send(15, 119 & 15, (i == 7) ? 1 : 0);
    chk("t3.B.sum", 32'(ib.out_sum), 32'd120);
    chk("t3.B.err", 32'(ib.out_err), 32'd0);

    // Backpressure on A: result held, no beat taken until release.
    do_reset();
    out_ready = 1'b0;
    send(5, 7, 0);
    send(4, 7, 1);
    in_valid = 1'b1; in_data = 4'd1; in_thr = 4'd0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4.A.in_ready", 32'(ia.in_ready), 32'd0);
      chk("t4.A.sum_hold", 32'(ia.out_sum),  32'd9);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4.A.valid_drained", 32'(ia.out_valid), 32'd0);
    in_data = 4'd2; in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4.A.sum_next", 32'(ia.out_sum), 32'd3);
    chk("t4.A.err_next", 32'(ia.out_err), 32'd0);

    // Framing on B: single beat, then eight beats without last, then a clean frame.
    do_reset();
    send(6, 2, 1);
    chk("t5.B.sum1", 32'(ib.out_sum), 32'd6);
    chk("t5.B.err1", 32'(ib.out_err), 32'd1);
    chk("t5.A.err1", 32'(ia.out_err), 32'd1);
    for (int i = 0; i < 8; i++) send(1, 0, 0);
    chk("t5.B.sum8", 32'(ib.out_sum), 32'd8);
    chk("t5.B.err8", 32'(ib.out_err), 32'd1);
    for (int i = 0; i < 8; i++) send(2, 15, (i == 7) ? 1 : 0);
    chk("t5.B.sum_clean", 32'(ib.out_sum), 32'd16);
    chk("t5.B.bit_clean", 32'(ib.out_bit), 32'd1);
    chk("t5.B.err_clean", 32'(ib.out_err), 32'd0);

    // Reset mid-frame, then with a pending result, then a fresh frame.
    do_reset();
    send(1, 0, 0);
    do_reset();
    chk_zero("t6.mid");
    out_ready = 1'b0;
    send(5, 7, 0);
    send(4, 7, 1);
    do_reset();
    chk_zero("t6.pend");
    out_ready = 1'b1;
    send(2, 3, 0);
    send(2, 3, 1);
    chk("t6.A.sum", 32'(ia.out_sum), 32'd4);
    chk("t6.A.bit", 32'(ia.out_bit), 32'd1);

    // Random traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 4'($urandom_range(0, 15));
      in_thr    = 4'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
